mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Parametrised AXI4-Lite-style N-master to 1-slave arbiter between the core's memory clients (icache refill, LSU load/store, future DMA/debug masters) and the single external memory port.
- Independent read and write paths, each with its own FSM and grant logic.
- At most one outstanding transaction per direction.
- Selectable round-robin or fixed-priority arbitration. Supersedes the hard-wired two-client split at the core boundary.

Parameters:
- NUM_MASTERS, 2, number of upstream masters (1..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width; wstrb width is DATA_W/8
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- m_arvalid  in  N  per-master read address valid
- m_araddr  in  N*ADDR_W  per-master read address; master i occupies slice i
- m_arsize  in  N*3  per-master read size
- m_arready  out  N  per-master read address ready
- m_rvalid  out  N  per-master read data valid
- m_rdata  out  DATA_W  read data, shared by all masters
- m_rresp  out  2  read response, shared by all masters
- m_rready  in  N  per-master read data ready
- m_awvalid / m_awaddr / m_awready  in / in / out  N / N*ADDR_W / N  write address channel
- m_wvalid / m_wdata / m_wstrb / m_wready  in / in / in / out  N / N*DATA_W / N*DATA_W/8 / N  write data channel
- m_bvalid / m_bresp / m_bready  out / out / in  N / 2 / N  write response channel
- s_arvalid s_araddr s_arsize s_arready s_rvalid s_rdata s_rresp s_rready: slave read side, widths as above with N = 1
- s_awvalid s_awaddr s_awready s_wvalid s_wdata s_wstrb s_wready s_bvalid s_bresp s_bready: slave write side, widths as above with N = 1

Behaviour:
- Reset (reset == 0 at a clock edge):
  - Both FSMs go to IDLE; both round-robin pointers go to 0.
  - All m_*ready, m_rvalid, m_bvalid, s_*valid, s_rready and s_bready read 0 from the following cycle.
  - Reset in the middle of a transaction abandons it; no response is forwarded afterwards.
- Read FSM, states R_IDLE → R_ADDR → R_DATA → R_IDLE:
  - R_IDLE: if any m_arvalid is set, register the grant index and go to R_ADDR. Master arvalid at cycle t gives s_arvalid at t+1.
  - R_ADDR: s_arvalid = 1. s_araddr and s_arsize are driven from the granted slice. m_arready[g] = s_arready, combinational pass-through; all other m_arready are 0. On s_arvalid & s_arready, go to R_DATA.
  - R_DATA: m_rvalid[g] = s_rvalid and s_rready = m_rready[g]. m_rdata and m_rresp come straight from the slave. On the R handshake, go to R_IDLE.
- Write FSM, states W_IDLE → W_REQ → W_RESP → W_IDLE:
  - W_REQ: AW and W are forwarded independently for the granted master, each tracked by a done flag. AW and W may complete in the same cycle or in either order.
  - Go to W_RESP once both done flags are set. Forward B to master g the same way R is forwarded, then return to W_IDLE.
- Arbitration:
  - Round-robin: search order starts at ptr and runs ptr, ptr+1, ... modulo NUM_MASTERS. After a grant to g, ptr becomes (g+1) mod NUM_MASTERS; the update happens on the IDLE→ADDR/REQ transition.
  - Fixed priority: the lowest set index wins; the pointer is unused.
  - The grant is stable for the whole transaction. Requests arriving mid-transaction wait.
  - Minimum read turnaround is 3 cycles per transaction. A new grant is evaluated only in the IDLE cycle after the R or B handshake.
- Masters must hold valid and payload until ready. The arbiter does not latch payload; it muxes combinationally from the granted slice.
- Read and write paths never block each other. The same master may hold a read grant and a write grant at once.
- NUM_MASTERS = 1: the grant is always 0. Behaviour is identical otherwise, including the one-cycle IDLE bubble.

Decomposition:
- Shared header `arb_param.vh` holds: FSM state encodings (2-bit R_*/W_* codes), the ARB_MODE constants, and resp codes OKAY = 2'b00 and SLVERR = 2'b10.
- One sub-module, `rr_arbiter`: parameters N and MODE; inputs req[N-1:0] and update; outputs grant_idx and grant_valid. It is instantiated twice, once for reads and once for writes.

Test Plan:
- Single read, N = 2, ARB_MODE = 0:
  - Stimulus: m_arvalid = 01, addr 0x8000_0000; slave arready at t+2; rdata 0xDEADBEEF at t+4.
  - Required: s_arvalid rises at t+1; m_rvalid[0] at t+4 with data 0xDEADBEEF; m_rvalid[1] stays 0.
- Contention under round-robin:
  - Stimulus: both masters hold arvalid continuously for 4 transactions.
  - Required: grants alternate 0,1,0,1; each read returns its own address tag.
- Fixed priority:
  - Stimulus: ARB_MODE = 1, N = 4, masters 1 and 3 request continuously.
  - Required: master 1 wins every time; master 3 is served only after master 1 drops its request.
- Write ordering:
  - Stimulus: master 1 sends W (data 0x1234_5678, strb 4'b0011) two cycles before AW (addr 0x1000).
  - Required: s_bready and m_bvalid[1] appear only after both handshakes; the slave sees strb 0011.
- Concurrent read and write:
  - Stimulus: master 0 issues a read while master 1 issues a write in the same cycle.
  - Required: both complete; neither stalls the other.
- Mid-transaction reset:
  - Stimulus: assert reset low while in R_DATA.
  - Required: next cycle, all valids and readies are 0 and the pointer is 0; a following read from master 1 gets the grant first.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state codes, arbitration
// mode selectors, AXI response codes and an index-width helper.
// No logic, no latency, no backpressure; imported by mem_arbiter and rr_arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_ADDR = 2'b01,
        R_DATA = 2'b10
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_REQ  = 2'b01,
        W_RESP = 2'b10
    } wr_state_e;

    localparam int ARB_RR    = 0;   // round-robin
    localparam int ARB_FIXED = 1;   // fixed priority, lowest index wins

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Grant index width; a single master still gets a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Request arbiter: combinational grant from req, round-robin or fixed priority.
// Latency: grant is combinational; the rotation pointer advances on update.
// Backpressure: none; caller asserts update only when it accepts the grant.
// Ports: clock/reset (sync active-low), req[N-1:0], update -> grant_idx, grant_valid.
module rr_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N    = 2,
    parameter int MODE = ARB_RR
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N-1:0]          req,
    input  logic                  update,
    output logic [idx_w(N)-1:0]   grant_idx,
    output logic                  grant_valid
);

    localparam int IW = idx_w(N);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] base;
    logic [IW:0]   cand;

    // Fixed priority always searches from master 0.
    assign base = (MODE == ARB_FIXED) ? '0 : ptr_q;

    // Search base, base+1, ... modulo N; first requester wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, base} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!grant_valid && req[cand[IW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[IW-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr_q <= '0;
        end else if (MODE == ARB_RR && update && grant_valid) begin
            ptr_q <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-master to 1-slave AXI4-Lite-style arbiter with independent read/write paths.
// Latency: master valid at t -> slave valid at t+1; one outstanding txn per direction.
// Backpressure: ready/valid pass-through for the granted master only; others wait.
// Ports: m_* per-master AR/R/AW/W/B (slice i = master i), s_* single slave side,
// clock, reset (synchronous, active-low).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ARB_MODE    = ARB_RR
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_MASTERS-1:0]          m_arvalid,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_araddr,
    input  logic [NUM_MASTERS*3-1:0]        m_arsize,
    output logic [NUM_MASTERS-1:0]          m_arready,
    output logic [NUM_MASTERS-1:0]          m_rvalid,
    output logic [DATA_W-1:0]               m_rdata,
    output logic [1:0]                      m_rresp,
    input  logic [NUM_MASTERS-1:0]          m_rready,
    input  logic [NUM_MASTERS-1:0]          m_awvalid,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_awaddr,
    output logic [NUM_MASTERS-1:0]          m_awready,
    input  logic [NUM_MASTERS-1:0]          m_wvalid,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_wstrb,
    output logic [NUM_MASTERS-1:0]          m_wready,
    output logic [NUM_MASTERS-1:0]          m_bvalid,
    output logic [1:0]                      m_bresp,
    input  logic [NUM_MASTERS-1:0]          m_bready,
    output logic                            s_arvalid,
    output logic [ADDR_W-1:0]               s_araddr,
    output logic [2:0]                      s_arsize,
    input  logic                            s_arready,
    input  logic                            s_rvalid,
    input  logic [DATA_W-1:0]               s_rdata,
    input  logic [1:0]                      s_rresp,
    output logic                            s_rready,
    output logic                            s_awvalid,
    output logic [ADDR_W-1:0]               s_awaddr,
    input  logic                            s_awready,
    output logic                            s_wvalid,
    output logic [DATA_W-1:0]               s_wdata,
    output logic [DATA_W/8-1:0]             s_wstrb,
    input  logic                            s_wready,
    input  logic                            s_bvalid,
    input  logic [1:0]                      s_bresp,
    output logic                            s_bready
);

    localparam int N      = NUM_MASTERS;
    localparam int IW     = idx_w(N);
    localparam int STRB_W = DATA_W / 8;

    // ---------------- read path ----------------
    rd_state_e     r_state_q;
    logic [IW-1:0] r_gnt_q;
    logic [IW-1:0] r_gnt_idx;
    logic          r_gnt_vld;
    logic          s_arvalid_q;

    rr_arbiter #(.N(N), .MODE(ARB_MODE)) u_rd_arb (
        .clock       (clock),
        .reset       (reset),
        .req         (m_arvalid),
        .update      (r_state_q == R_IDLE),
        .grant_idx   (r_gnt_idx),
        .grant_valid (r_gnt_vld)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state_q   <= R_IDLE;
            r_gnt_q     <= '0;
            s_arvalid_q <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: if (r_gnt_vld) begin
                    r_gnt_q     <= r_gnt_idx;
                    s_arvalid_q <= 1'b1;
                    r_state_q   <= R_ADDR;
                end
                R_ADDR: if (s_arready) begin
                    s_arvalid_q <= 1'b0;
                    r_state_q   <= R_DATA;
                end
                R_DATA: if (s_rvalid && m_rready[r_gnt_q]) begin
                    r_state_q <= R_IDLE;
                end
                default: begin
                    s_arvalid_q <= 1'b0;
                    r_state_q   <= R_IDLE;
                end
            endcase
        end
    end

    assign s_arvalid = s_arvalid_q;
    assign s_araddr  = m_araddr[int'(r_gnt_q)*ADDR_W +: ADDR_W];
    assign s_arsize  = m_arsize[int'(r_gnt_q)*3 +: 3];
    assign m_rdata   = s_rdata;
    assign m_rresp   = s_rresp;

    always_comb begin
        m_arready = '0;
        m_rvalid  = '0;
        s_rready  = 1'b0;
        if (r_state_q == R_ADDR) begin
            m_arready[r_gnt_q] = s_arready;
        end
        if (r_state_q == R_DATA) begin
            m_rvalid[r_gnt_q] = s_rvalid;
            s_rready          = m_rready[r_gnt_q];
        end
    end

    // ---------------- write path ----------------
    wr_state_e     w_state_q;
    logic [IW-1:0] w_gnt_q;
    logic [IW-1:0] w_gnt_idx;
    logic          w_gnt_vld;
    logic          aw_done_q;
    logic          w_done_q;
    logic          aw_hs;
    logic          w_hs;

    // A write is requested as soon as either half shows up.
    rr_arbiter #(.N(N), .MODE(ARB_MODE)) u_wr_arb (
        .clock       (clock),
        .reset       (reset),
        .req         (m_awvalid | m_wvalid),
        .update      (w_state_q == W_IDLE),
        .grant_idx   (w_gnt_idx),
        .grant_valid (w_gnt_vld)
    );

    // AW and W complete independently; each half is masked once it has handshaked.
    assign s_awvalid = (w_state_q == W_REQ) && m_awvalid[w_gnt_q] && !aw_done_q;
    assign s_wvalid  = (w_state_q == W_REQ) && m_wvalid[w_gnt_q]  && !w_done_q;
    assign aw_hs     = s_awvalid && s_awready;
    assign w_hs      = s_wvalid  && s_wready;
    assign s_awaddr  = m_awaddr[int'(w_gnt_q)*ADDR_W +: ADDR_W];
    assign s_wdata   = m_wdata[int'(w_gnt_q)*DATA_W +: DATA_W];
    assign s_wstrb   = m_wstrb[int'(w_gnt_q)*STRB_W +: STRB_W];
    assign m_bresp   = s_bresp;

    always_ff @(posedge clock) begin
        if (!reset) begin
            w_state_q <= W_IDLE;
            w_gnt_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: if (w_gnt_vld) begin
                    w_gnt_q   <= w_gnt_idx;
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    w_state_q <= W_REQ;
                end
                W_REQ: begin
                    aw_done_q <= aw_done_q | aw_hs;
                    w_done_q  <= w_done_q  | w_hs;
                    if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: if (s_bvalid && m_bready[w_gnt_q]) begin
                    w_state_q <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        s_bready  = 1'b0;
        if (w_state_q == W_REQ) begin
            m_awready[w_gnt_q] = s_awready && !aw_done_q;
            m_wready[w_gnt_q]  = s_wready  && !w_done_q;
        end
        if (w_state_q == W_RESP) begin
            m_bvalid[w_gnt_q] = s_bvalid;
            s_bready          = m_bready[w_gnt_q];
        end
    end

endmodule
